axi_rd_arbiter: RTL and testbench

//  Two-master to one-slave AXI4-Lite read-channel arbiter (AR + R only). Shares the single

---
 rtl/axi_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 20 ++
 rtl/axi_rd_arbiter.sv | 145 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4-Lite read-channel constants and the read arbiter's state encoding.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_ERR,
    S_DRAIN
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request picker: round-robin against last_grant, or fixed priority to req[1].
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Contention: m0 only wins when rotating away from a previous m1 grant.
      2'b11:   gnt = (rr_en && last_grant) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4-Lite read arbiter (AR + R), one outstanding read, with response watchdog.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter bit RR_EN   = 1'b1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TMO_MAX  = '1;

  arb_state_t        state;
  logic              grant;  // 0: m0, 1: m1; doubles as last_grant while idle
  logic [ADDR_W-1:0] addr_q;
  logic [TW-1:0]     tmo_cnt;
  logic [1:0]        pick;
  logic              m_rready;
  logic              r_hs;
  logic              tmo_hit;
  logic              r_vld;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  rr_arbiter2 u_arb (
    .req       ({m1_arvalid, m0_arvalid}),
    .last_grant(grant),
    .rr_en     (RR_EN),
    .gnt       (pick)
  );

  assign m_rready = grant ? m1_rready : m0_rready;
  assign r_hs     = (state == S_R) && s_rvalid && m_rready;
  assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      grant   <= 1'b0;
      addr_q  <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|pick) begin
            grant  <= pick[1];
            addr_q <= pick[1] ? m1_araddr : m0_araddr;
            state  <= S_AR;
          end
        end
        S_AR: begin
          if (s_arready) begin
            tmo_cnt <= '0;
            state   <= S_R;
          end
        end
        S_R: begin
          if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
          // A beat landing on the last allowed cycle beats the watchdog.
          if (r_hs)         state <= S_IDLE;
          else if (tmo_hit) state <= S_ERR;
        end
        S_ERR: begin
          if (m_rready) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (s_rvalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign s_arvalid = (state == S_AR);
  assign s_araddr  = addr_q;

  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_rready   = 1'b0;
    r_vld      = 1'b0;
    r_data     = '0;
    r_resp     = RESP_OKAY;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = RESP_OKAY;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = RESP_OKAY;
    case (state)
      S_IDLE: begin
        m0_arready = pick[0] & rst;
        m1_arready = pick[1] & rst;
      end
      S_R: begin
        r_vld    = s_rvalid;
        r_data   = s_rdata;
        r_resp   = s_rresp;
        s_rready = m_rready;
      end
      S_ERR: begin
        r_vld  = 1'b1;
        r_resp = RESP_SLVERR;
      end
      S_DRAIN: s_rready = 1'b1;
      default: ;
    endcase
    if (grant) begin
      m1_rvalid = r_vld;
      m1_rdata  = r_data;
      m1_rresp  = r_resp;
    end else begin
      m0_rvalid = r_vld;
      m0_rdata  = r_data;
      m0_rresp  = r_resp;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: slave responder model plus an R-beat scoreboard.
module tb_axi_rd_arbiter;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr;
  logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
  logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic [31:0] s_araddr, s_rdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_rresp;
  logic        fp_m0_arready, fp_m1_arready, fp_m0_rvalid, fp_m1_rvalid;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_araddr;
  logic [1:0]  fp_m0_rresp, fp_m1_rresp;
  logic        fp_s_arvalid, fp_s_rready;

  int   n_vec = 0;
  int   n_err = 0;
  int   sl_ar_wait = 0;
  int   sl_r_wait = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  // Fixed-priority twin fed the same stimulus; it tracks dut cycle-for-cycle.
  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0), .TIMEOUT(8)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(fp_m0_arready),
    .m0_rdata(fp_m0_rdata), .m0_rresp(fp_m0_rresp), .m0_rvalid(fp_m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(fp_m1_arready),
    .m1_rdata(fp_m1_rdata), .m1_rresp(fp_m1_rresp), .m1_rvalid(fp_m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(fp_s_araddr), .s_arvalid(fp_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(fp_s_rready)
  );

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic port, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("r_beat", 64'({port, d, r}), 64'(e));
    end
  endtask

  // R-channel monitor: every accepted beat must match the next expected entry.
  always @(negedge clk) begin
    if (rst) begin
      if (m0_rvalid || m1_rvalid) chk("one_rvalid", 64'(m0_rvalid && m1_rvalid), 64'd0);
      if (m0_rvalid && m0_rready) beat(1'b0, m0_rdata, m0_rresp);
      if (m1_rvalid && m1_rready) beat(1'b1, m1_rdata, m1_rresp);
    end
  end

  // Slave responder: arready after sl_ar_wait cycles of arvalid, rvalid sl_r_wait cycles later.
  initial begin : slave_model
    int st, cnt;
    logic [31:0] a;
    logic ar_hs, r_hs, ar_seen;
    st = 0; cnt = 0; a = '0; ar_hs = 1'b0; r_hs = 1'b0; ar_seen = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
    forever begin
      @(negedge clk);
      ar_seen = s_arvalid;
      ar_hs   = s_arvalid && s_arready;
      r_hs    = s_rvalid && s_rready;
      if (ar_hs) a = s_araddr;
      @(posedge clk); #2;
      if (!rst) begin
        st = 0; cnt = 0; s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
      end else begin
        if (st == 0) begin
          if (ar_hs) begin
            st = 1; cnt = 0; s_arready = 1'b0;
          end else begin
            if (ar_seen) cnt++;
            s_arready = (cnt >= sl_ar_wait);
          end
        end
        if (st == 1) begin
          if (cnt >= sl_r_wait) begin
            s_rvalid = 1'b1; s_rdata = slv_data(a); s_rresp = 2'b00; st = 2;
          end else cnt++;
        end else if (st == 2 && r_hs) begin
          s_rvalid = 1'b0; s_rdata = '0; st = 0; cnt = 0; s_arready = (sl_ar_wait == 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ar(output logic [1:0] g, output int n);
    g = 2'b00;
    n = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m0_arready || m1_arready) begin
        g = {m1_arready, m0_arready};
        n = i;
        break;
      end
      tick();
    end
  endtask

  task automatic req(input logic port, input logic [31:0] addr, input bit push, input bit err);
    logic [1:0] g;
    int n;
    if (port) begin m1_araddr = addr; m1_arvalid = 1'b1; end
    else      begin m0_araddr = addr; m0_arvalid = 1'b1; end
    if (push) sb.push_back(exp_t'{port, err ? 32'h0 : slv_data(addr), err ? 2'b10 : 2'b00});
    wait_ar(g, n);
    chk("ar_grant", 64'(g), port ? 64'd2 : 64'd1);
    tick();
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    repeat (2) tick();
  endtask

  initial begin : global_bound
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0] g;
    logic [1:0] rr_exp [4];
    int n, nwait;
    bit found;
    rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};

    rst = 1'b0;
    m0_araddr = '0; m1_araddr = '0; m0_arvalid = 1'b1; m1_arvalid = 1'b0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_vld_rdy", 64'({m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready}), 64'd0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    chk("rst_resp_addr", 64'({m0_rresp, m1_rresp, s_araddr}), 64'd0);
    chk("rst_fp_vld_rdy", 64'({fp_m0_arready, fp_m1_arready, fp_m0_rvalid, fp_m1_rvalid, fp_s_arvalid, fp_s_rready}), 64'd0);
    chk("rst_fp_rdata", {fp_m0_rdata, fp_m1_rdata}, 64'd0);
    chk("rst_fp_resp_addr", 64'({fp_m0_rresp, fp_m1_rresp, fp_s_araddr}), 64'd0);
    tick();
    rst = 1'b1;
    m0_arvalid = 1'b0;
    tick();

    // Single zero-wait read from m0, cycle by cycle.
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
    sb.push_back(exp_t'{1'b0, 32'hDEAD_BEEF, 2'b00});
    @(negedge clk);
    chk("t2_c1_arready", 64'({m1_arready, m0_arready}), 64'd1);
    tick();
    m0_arvalid = 1'b0;
    @(negedge clk);
    chk("t2_c2_s_ar", 64'({s_arvalid, s_araddr}), 64'({1'b1, 32'h8000_0000}));
    tick();
    @(negedge clk);
    chk("t2_c3_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd2);
    chk("t2_c3_rdata", 64'({m0_rresp, m0_rdata}), 64'({2'b00, 32'hDEAD_BEEF}));
    tick();
    wait_idle("t2_done");

    // Contention with both masters held: rr alternates, fixed priority keeps m1.
    m0_araddr = 32'h0000_0100; m1_araddr = 32'h0000_0200;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    for (int i = 0; i < 4; i++)
      sb.push_back(exp_t'{rr_exp[i][1], slv_data(rr_exp[i][1] ? 32'h0000_0200 : 32'h0000_0100), 2'b00});
    for (int i = 0; i < 4; i++) begin
      wait_ar(g, n);
      chk("t3_rr_grant", 64'(g), 64'(rr_exp[i]));
      chk("t3_fp_grant", 64'({fp_m1_arready, fp_m0_arready}), 64'd2);
      if (i > 0) chk("t3_b2b_gap", 64'(n), 64'd2);
      tick();
      if (i == 3) begin m0_arvalid = 1'b0; m1_arvalid = 1'b0; end
    end
    wait_idle("t3_done");

    // Backpressure: slow arready, then m1 stalls the R beat.
    sl_ar_wait = 5;
    m1_araddr = 32'h0000_1000; m1_arvalid = 1'b1;
    sb.push_back(exp_t'{1'b1, slv_data(32'h0000_1000), 2'b00});
    wait_ar(g, n);
    chk("t4_grant", 64'(g), 64'd2);
    tick();
    m1_arvalid = 1'b0;
    nwait = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_ar_hold", 64'({s_arvalid, s_araddr}), 64'({1'b1, 32'h0000_1000}));
      if (s_arready) break;
      nwait++;
      tick();
    end
    chk("t4_ar_wait_cycles", 64'(nwait), 64'd5);
    tick();
    sl_ar_wait = 0;
    m1_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_r_stall", 64'({s_rready, m1_rvalid, m1_rdata}), 64'({1'b0, 1'b1, slv_data(32'h0000_1000)}));
      tick();
    end
    m1_rready = 1'b1;
    wait_idle("t4_done");

    // Watchdog: slave answers far too late for m1.
    sl_r_wait = 12;
    req(1'b1, 32'h0000_2000, 1'b1, 1'b1);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m1_rvalid) begin found = 1'b1; break; end
      if (s_rready) n++;
      tick();
    end
    chk("t5_tmo_seen", 64'(found), 64'd1);
    chk("t5_tmo_cycles", 64'(n), 64'd8);
    chk("t5_err_beat", 64'({m1_rvalid, m1_rresp, m1_rdata, s_rready}), 64'({1'b1, 2'b10, 32'h0, 1'b0}));
    tick();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_drain_quiet", 64'({m0_rvalid, m1_rvalid}), 64'd0);
      if (s_rvalid && s_rready) found = 1'b1;
      tick();
      if (found) break;
    end
    chk("t5_drained", 64'(found), 64'd1);
    sl_r_wait = 0;
    req(1'b0, 32'h0000_3000, 1'b1, 1'b0);
    wait_idle("t5_after");

    // Beat arrives on the last cycle before the watchdog fires.
    sl_r_wait = 7;
    req(1'b0, 32'h0000_4000, 1'b1, 1'b0);
    wait_idle("t6_edge_okay");
    sl_r_wait = 0;

    // Reset in the middle of S_R aborts the read.
    sl_r_wait = 30;
    req(1'b0, 32'h0000_5000, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_rst_async", 64'({m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready}), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_rst_next", 64'({m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready}), 64'd0);
    chk("t1_rst_addr", 64'(s_araddr), 64'd0);
    tick();
    rst = 1'b1;
    sl_r_wait = 0;
    tick();
    req(1'b0, 32'h0000_6000, 1'b1, 1'b0);
    wait_idle("t1_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
